// File: rtl/rgb_stream_packer_if.sv
// Pixel-in / AXI4-Stream-out signal bundle for rgb_stream_packer.
// slave is the packer's view; master is the view of the pixel source plus stream sink.
interface rgb_stream_packer_if;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        valid;
    logic        sof;
    logic        eol;
    logic        in_stream_ready;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;

    modport slave (
        input  r, g, b, valid, sof, eol, out_stream_tready,
        output in_stream_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tlast, out_stream_tuser, out_stream_tvalid
    );

    modport master (
        output r, g, b, valid, sof, eol, out_stream_tready,
        input  in_stream_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tlast, out_stream_tuser, out_stream_tvalid
    );
endinterface

// File: rtl/rgb_stream_packer.sv
// Packs 24-bit RGB pixels into a gapless little-endian 32-bit AXI4-Stream (4 px -> 3 words),
// flushing partial words at end of line and re-aligning on start of frame.
module rgb_stream_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic               aclk,
    input  logic               areset,
    rgb_stream_packer_if.slave bus,
    output logic               misalign_err
);
    typedef enum logic {RUN, FLUSH} state_t;

    state_t      state, state_n;
    logic [1:0]  phase, phase_n, eff_phase;
    logic [23:0] residue, residue_n;
    logic        sof_pend, sof_pend_n, err_n;
    logic [23:0] pix;
    logic        out_free, accept;
    logic        load, word_last, word_user;
    logic [31:0] word;
    logic [31:0] tdata_q;
    logic        tlast_q, tuser_q, tvalid_q;

    assign pix                   = {bus.r, bus.g, bus.b};
    assign out_free              = !tvalid_q || bus.out_stream_tready;
    assign bus.in_stream_ready   = (state == RUN) && out_free;
    assign accept                = bus.valid && bus.in_stream_ready;
    assign bus.out_stream_tdata  = tdata_q;
    assign bus.out_stream_tkeep  = '1;
    assign bus.out_stream_tlast  = tlast_q;
    assign bus.out_stream_tuser  = tuser_q;
    assign bus.out_stream_tvalid = tvalid_q;

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        residue_n  = residue;
        sof_pend_n = sof_pend;
        err_n      = misalign_err;
        load       = 1'b0;
        word       = '0;
        word_last  = 1'b0;
        word_user  = 1'b0;
        // SOF re-aligns the group: any residue is discarded and the pixel packs as ph0.
        eff_phase  = bus.sof ? 2'd0 : phase;

        if (state == FLUSH) begin
            if (out_free) begin
                load      = 1'b1;
                word_last = 1'b1;
                word      = (phase == 2'd2) ? {PAD_BYTE, PAD_BYTE, residue[15:0]}
                                            : {PAD_BYTE, PAD_BYTE, PAD_BYTE, residue[7:0]};
                state_n   = RUN;
                phase_n   = 2'd0;
                residue_n = '0;
            end
        end else if (accept) begin
            if (bus.sof) begin
                sof_pend_n = 1'b1;
                if (phase != 2'd0) err_n = 1'b1;
            end
            case (eff_phase)
                2'd0: begin
                    if (bus.eol) begin
                        load      = 1'b1;
                        word      = {PAD_BYTE, pix};
                        word_last = 1'b1;
                        phase_n   = 2'd0;
                        residue_n = '0;
                    end else begin
                        residue_n = pix;
                        phase_n   = 2'd1;
                    end
                end
                2'd1: begin
                    load      = 1'b1;
                    word      = {pix[7:0], residue[23:0]};
                    residue_n = {8'h00, pix[23:8]};
                    phase_n   = 2'd2;
                    if (bus.eol) state_n = FLUSH;
                end
                2'd2: begin
                    load      = 1'b1;
                    word      = {pix[15:0], residue[15:0]};
                    residue_n = {16'h0000, pix[23:16]};
                    phase_n   = 2'd3;
                    if (bus.eol) state_n = FLUSH;
                end
                2'd3: begin
                    load      = 1'b1;
                    word      = {pix, residue[7:0]};
                    residue_n = '0;
                    phase_n   = 2'd0;
                    word_last = bus.eol;
                end
            endcase
        end

        // FLUSH keeps phase at 2 or 3 so it knows how many residue bytes remain.
        if (load) begin
            word_user  = sof_pend_n;
            sof_pend_n = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state        <= RUN;
            phase        <= '0;
            residue      <= '0;
            sof_pend     <= 1'b0;
            misalign_err <= 1'b0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            residue      <= residue_n;
            sof_pend     <= sof_pend_n;
            misalign_err <= err_n;
            if (load) begin
                tvalid_q <= 1'b1;
                tdata_q  <= word;
                tlast_q  <= word_last;
                tuser_q  <= word_user;
            end else if (bus.out_stream_tready) begin
                tvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rgb_stream_packer.sv
// Randomized bench for rgb_stream_packer: a byte-stream reference model predicts every
// output word (data, tlast, tuser) and the sticky misalignment flag.
module tb_rgb_stream_packer;
    localparam logic [7:0] PAD = 8'h00;

    logic aclk = 1'b0;
    logic areset;
    logic misalign_err;

    rgb_stream_packer_if bus ();

    rgb_stream_packer #(.PAD_BYTE(PAD)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .bus          (bus),
        .misalign_err (misalign_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [23:0] p;
        bit          sof;
        bit          eol;
    } px_t;

    typedef struct {
        logic [31:0] d;
        bit          last;
        bit          user;
    } wd_t;

    px_t          px_q[$];
    wd_t          exp_q[$];
    logic [7:0]   pend[$];
    bit           m_sof_pend;
    bit           m_err;
    int           n_tests;
    int           n_fail;
    logic [23:0]  line_px[640];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add_px(input logic [23:0] p, input bit sof, input bit eol);
        px_t e;
        e.p = p; e.sof = sof; e.eol = eol;
        px_q.push_back(e);
    endtask

    task automatic emit_word(input bit last);
        wd_t w;
        w.d    = {pend[3], pend[2], pend[1], pend[0]};
        w.last = last;
        w.user = m_sof_pend;
        m_sof_pend = 1'b0;
        repeat (4) void'(pend.pop_front());
        exp_q.push_back(w);
    endtask

    // Each line is a byte stream (b, g, r per pixel) cut into 4-byte words.
    task automatic model_px(input px_t e);
        if (e.sof) begin
            if (pend.size() != 0) m_err = 1'b1;
            pend.delete();
            m_sof_pend = 1'b1;
        end
        pend.push_back(e.p[7:0]);
        pend.push_back(e.p[15:8]);
        pend.push_back(e.p[23:16]);
        while (pend.size() >= 4) emit_word(1'b0);
        if (e.eol) begin
            if (pend.size() != 0) begin
                while (pend.size() < 4) pend.push_back(PAD);
                emit_word(1'b1);
            end else if (exp_q.size() != 0) begin
                exp_q[exp_q.size()-1].last = 1'b1;
            end
        end
    endtask

    task automatic run(input int budget, input bit rnd, input bit stop_after_px,
                       output int not_ready, output int words);
        int cyc;
        wd_t w;
        cyc = 0; not_ready = 0; words = 0;
        while (cyc < budget && (px_q.size() > 0 ||
               (!stop_after_px && (exp_q.size() > 0 || bus.out_stream_tvalid === 1'b1)))) begin
            @(negedge aclk);
            bus.out_stream_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.valid = (px_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
            if (px_q.size() > 0) begin
                {bus.r, bus.g, bus.b} = px_q[0].p;
                bus.sof = px_q[0].sof;
                bus.eol = px_q[0].eol;
            end else begin
                bus.sof = 1'b0;
                bus.eol = 1'b0;
            end
            #1;
            if (bus.out_stream_tready && !bus.in_stream_ready) not_ready++;
            if (bus.out_stream_tvalid) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_word", {bus.out_stream_tuser, bus.out_stream_tlast,
                             bus.out_stream_tdata}, 64'h0);
                end else begin
                    w = exp_q[0];
                    check_eq("word", {bus.out_stream_tuser, bus.out_stream_tlast,
                             bus.out_stream_tdata}, {w.user, w.last, w.d});
                    if (bus.out_stream_tready) begin
                        void'(exp_q.pop_front());
                        words++;
                    end
                end
            end
            if (bus.valid && bus.in_stream_ready) model_px(px_q.pop_front());
            cyc++;
        end
        if (cyc >= budget) check_eq("timeout_left", 64'(px_q.size() + exp_q.size()), 64'h0);
        @(negedge aclk);
        bus.valid = 1'b0;
        bus.sof   = 1'b0;
        bus.eol   = 1'b0;
    endtask

    task automatic add_group1();
        add_px(24'h112233, 0, 0);
        add_px(24'h445566, 0, 0);
        add_px(24'h778899, 0, 0);
        add_px(24'hAABBCC, 0, 0);
    endtask

    int nr, nw, len;

    initial begin
        n_tests = 0; n_fail = 0; m_sof_pend = 0; m_err = 0;
        bus.valid = 0; bus.sof = 0; bus.eol = 0;
        bus.r = 0; bus.g = 0; bus.b = 0;
        bus.out_stream_tready = 1;
        areset = 1;
        repeat (3) @(negedge aclk);
        #1;
        check_eq("rst_tvalid", 64'(bus.out_stream_tvalid), 64'h0);
        check_eq("rst_tdata",  64'(bus.out_stream_tdata), 64'h0);
        check_eq("rst_tlast",  64'(bus.out_stream_tlast), 64'h0);
        check_eq("rst_tuser",  64'(bus.out_stream_tuser), 64'h0);
        check_eq("rst_tkeep",  64'(bus.out_stream_tkeep), 64'hF);
        check_eq("rst_err",    64'(misalign_err), 64'h0);
        check_eq("rst_ready",  64'(bus.in_stream_ready), 64'h1);
        areset = 0;

        // Basic group: expect 66112233, 88994455, AABBCC77.
        add_group1();
        run(100, 0, 0, nr, nw);
        check_eq("t1_words", 64'(nw), 64'd3);

        // 6-px line ending at ph1: one FLUSH cycle and a padded tail word.
        add_group1();
        add_px(24'hDDEEFF, 0, 0);
        add_px(24'h123456, 0, 1);
        run(100, 0, 0, nr, nw);
        check_eq("t3_words", 64'(nw), 64'd5);
        check_eq("t3_flush_cycles", 64'(nr), 64'd1);

        // Full 640-px line, then the same line under random backpressure.
        for (int i = 0; i < 640; i++) line_px[i] = 24'($urandom);
        for (int i = 0; i < 640; i++) add_px(line_px[i], i == 0, i == 639);
        run(2000, 0, 0, nr, nw);
        check_eq("t2_words", 64'(nw), 64'd480);
        check_eq("t2_err", 64'(misalign_err), 64'(m_err));
        for (int i = 0; i < 640; i++) add_px(line_px[i], i == 0, i == 639);
        run(6000, 1, 0, nr, nw);
        check_eq("t4_words", 64'(nw), 64'd480);

        // SOF on the 2nd pixel of a group, then an aligned line.
        add_px(24'hA1A2A3, 0, 0);
        add_px(24'hB1B2B3, 1, 0);
        add_px(24'hC1C2C3, 0, 0);
        add_px(24'hD1D2D3, 0, 1);
        run(100, 0, 0, nr, nw);
        check_eq("t5_err", 64'(misalign_err), 64'(m_err));
        check_eq("t5_err_set", 64'(misalign_err), 64'h1);
        for (int i = 0; i < 5; i++) add_px(24'($urandom), i == 0, i == 4);
        run(100, 1, 0, nr, nw);
        check_eq("t5_err_sticky", 64'(misalign_err), 64'h1);

        // Random line widths with random gaps and backpressure.
        for (int l = 0; l < 12; l++) begin
            len = $urandom_range(1, 23);
            for (int i = 0; i < len; i++) add_px(24'($urandom), l == 0 && i == 0, i == len - 1);
        end
        run(4000, 1, 0, nr, nw);
        check_eq("rnd_err", 64'(misalign_err), 64'(m_err));

        // Reset while in FLUSH.
        for (int i = 0; i < 6; i++) add_px(24'($urandom), 0, i == 5);
        run(100, 0, 1, nr, nw);
        #1;
        check_eq("t6_in_flush", 64'(bus.in_stream_ready), 64'h0);
        areset = 1;
        @(negedge aclk);
        areset = 0;
        #1;
        check_eq("t6_tvalid", 64'(bus.out_stream_tvalid), 64'h0);
        check_eq("t6_ready",  64'(bus.in_stream_ready), 64'h1);
        check_eq("t6_err",    64'(misalign_err), 64'h0);
        exp_q.delete(); pend.delete(); m_sof_pend = 0; m_err = 0;
        add_group1();
        run(100, 0, 0, nr, nw);
        check_eq("t6_words", 64'(nw), 64'd3);
        repeat (5) @(negedge aclk);
        #1;
        check_eq("t6_idle", 64'(bus.out_stream_tvalid), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
